pipe_hazard_ctrl: RTL

Parametrised hazard controller for the in-order RISC-V pipeline: tracks destination registers of in-flight instructions from EX through write-back, generates per-operand forwarding selects, load-use stalls and branch flushes. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It generalises the fixed two-operand, two-stage forwarding to configurable depth, operand count and load latency, and adds stall/flush control and event counters.

---
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the in-order pipeline: tracks in-flight destinations from EX onward and
// produces forwarding selects, load-use stalls, branch flushes and saturating event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned FWD_STAGES     = 2,
    parameter int unsigned LOAD_FWD_STAGE = 2,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned SEL_W          = $clog2(FWD_STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          en,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_reg_write,
    input  logic                          id_mem_read,
    input  logic                          br_taken,
    output logic                          stall_pc,
    output logic                          stall_if_id,
    output logic                          bubble_id_ex,
    output logic                          flush_if_id,
    output logic                          flush_id_ex,
    output logic                          flush_ex_mem,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    // Entry 0 is the instruction in EX; entries 1..FWD_STAGES are the stages after EX.
    logic [FWD_STAGES:0]           valid_q;
    logic [FWD_STAGES:0]           reg_write_q;
    logic [FWD_STAGES:0]           mem_read_q;
    logic [REG_ADDR_W-1:0]         rd_q [FWD_STAGES+1];
    logic [NUM_SRC*REG_ADDR_W-1:0] rs_q;
    logic [NUM_SRC-1:0]            rs_used_q;

    logic [FWD_STAGES:0] writer;
    logic                load_hit;
    logic                live;
    logic                stall;
    logic                flush;

    always_comb begin
        for (int j = 0; j <= int'(FWD_STAGES); j++) begin
            writer[j] = valid_q[j] && reg_write_q[j] && (rd_q[j] != '0);
        end
    end

    // A load whose data is not yet forwardable blocks a dependent instruction in ID.
    always_comb begin
        load_hit = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            for (int j = 0; j < int'(LOAD_FWD_STAGE) - 1; j++) begin
                if (id_rs_used[i] && writer[j] && mem_read_q[j] &&
                    (rd_q[j] == id_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    load_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        live  = en && !arst;
        flush = live && br_taken;
        stall = live && !br_taken && id_valid && load_hit;

        stall_pc     = stall;
        stall_if_id  = stall;
        bubble_id_ex = stall;
        flush_if_id  = flush;
        flush_id_ex  = flush;
        flush_ex_mem = flush;
    end

    // Scan oldest to youngest so the youngest eligible producer overrides.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (valid_q[0] && rs_used_q[i]) begin
                for (int k = int'(FWD_STAGES); k >= 1; k--) begin
                    if (writer[k] && (rd_q[k] == rs_q[i*REG_ADDR_W +: REG_ADDR_W]) &&
                        !(mem_read_q[k] && (k < int'(LOAD_FWD_STAGE)))) begin
                        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_q     <= '0;
            reg_write_q <= '0;
            mem_read_q  <= '0;
            for (int k = 0; k <= int'(FWD_STAGES); k++) begin
                rd_q[k] <= '0;
            end
            rs_q      <= '0;
            rs_used_q <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (en) begin
            for (int k = int'(FWD_STAGES); k >= 2; k--) begin
                valid_q[k]     <= valid_q[k-1];
                reg_write_q[k] <= reg_write_q[k-1];
                mem_read_q[k]  <= mem_read_q[k-1];
                rd_q[k]        <= rd_q[k-1];
            end
            valid_q[1]     <= valid_q[0] && !br_taken;
            reg_write_q[1] <= reg_write_q[0];
            mem_read_q[1]  <= mem_read_q[0];
            rd_q[1]        <= rd_q[0];

            valid_q[0]     <= id_valid && !stall && !br_taken;
            reg_write_q[0] <= id_reg_write;
            mem_read_q[0]  <= id_mem_read;
            rd_q[0]        <= id_rd;
            rs_q           <= id_rs;
            rs_used_q      <= id_rs_used;

            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
